mux_scan_reg: RTL and testbench
===============================

Name: mux_scan_reg

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Successor to the combinational 8:1 byte mux used in the labs.
- Two modes:
  - Manual: the channel is picked by `sel`.
  - Auto-scan: the block steps through the channels itself, staying on each for DWELL clocks.
- Feeds display and measurement paths that need a stable, timed, channel-tagged output.

Parameters:
W, 8, data width per channel
N, 8, number of channels (2..256)
SELW, 3, select/channel-index width, >= ceil(log2(N))
DWELL, 4, clocks spent on each channel in scan mode (>= 1)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
inp_bus  input  N*W  packed channel inputs; channel i = inp_bus[i*W +: W]
sel  input  SELW  manual channel select
mode  input  1  0 = manual, 1 = auto-scan
hold  input  1  scan mode only: freeze channel and dwell counters
w_out  output  W  registered selected data
ch_out  output  SELW  index of channel currently driving w_out
out_valid  output  1  w_out/ch_out hold valid data from a legal channel

Behaviour:
- Reset (async, rst=1):
  - w_out=0, ch_out=0, out_valid=0.
  - Internal cur=0, dwell count dc=0, state=IDLE.
  - Takes effect immediately and holds while rst=1, including mid-scan.
- State machine, states IDLE, MANUAL, SCAN, transitions evaluated each rising edge:
  - IDLE -> MANUAL if mode=0, -> SCAN if mode=1.
    - IDLE lasts exactly one clock after reset release.
    - During IDLE: out_valid=0, outputs hold reset values.
  - MANUAL -> SCAN when mode=1 is sampled.
    - On that edge cur<=0 and dc<=0.
    - Outputs on that edge still follow manual rules.
  - SCAN -> MANUAL when mode=0 is sampled.
    - On that edge cur<=0 and dc<=0.
    - Outputs take the manual value on that same edge.
- MANUAL (1-cycle latency):
  - If sel<N: w_out<=channel sel, ch_out<=sel, out_valid<=1.
  - If sel>=N (only possible when N < 2^SELW): w_out and ch_out hold their previous values, out_valid<=0.
- SCAN:
  - Each edge: w_out<=channel cur, ch_out<=cur, out_valid<=1.
  - Outputs lag cur by one clock.
  - If hold=0:
    - If dc==DWELL-1: dc<=0; cur<=(cur==N-1) ? 0 : cur+1 (wrap-around).
    - Else dc<=dc+1.
  - If hold=1: cur and dc unchanged; w_out keeps tracking live data on channel cur.
  - `sel` is ignored in SCAN.
  - DWELL=1: cur advances every clock.
- Input data changes are reflected at w_out on the next edge, in both modes.
- mode and hold are synchronous inputs with no internal synchronisation.
- Counter widths:
  - dc: ceil(log2(DWELL)) bits, minimum 1.
  - cur: SELW bits.
  - No arithmetic overflow is allowed: wrap is explicit at N-1.

Test Plan:
- Reset behaviour: assert rst mid-operation, asynchronously between edges → w_out=0, ch_out=0, out_valid=0 immediately. Release rst → first edge IDLE (out_valid=0), second edge valid.
- Manual select, N=8, W=8: inputs ch0..7 = AA, BA, BB, CB, CC, DC, DD, FF; mode=0; sel=2 → next edge w_out=BB, ch_out=2, out_valid=1. Step sel through 0..7 → outputs AA..FF in order, each 1 clock after sel changes.
- Scan wrap, DWELL=4, same inputs, mode=1:
  - w_out=AA for 4 clocks, then BA for 4 clocks, ... FF for 4 clocks, then AA again.
  - ch_out sequence 0..7,0.
  - out_valid stays 1 throughout.
- Hold during scan: assert hold on the 2nd clock of channel 5.
  - w_out stays DC for the whole hold time.
  - Change channel-5 input to 5A while holding → w_out=5A next edge.
  - Release hold → 2 more clocks at channel 5, then channel 6 (DD).
- Mode switch mid-scan: leave scan at channel 6 → next edge w_out=channel sel. Return to scan → restarts at ch0 (AA) with a full 4-clock dwell.
- Illegal select with N=6, SELW=3: sel=7 → out_valid=0 and w_out/ch_out hold their prior values. sel=1 → w_out=BA, out_valid=1.

Source files
------------

// File: rtl/mux_scan_reg_if.sv
// Channel bus for mux_scan_reg: packed channel inputs and controls in,
// registered channel-tagged data out.
interface mux_scan_reg_if #(
    parameter int W    = 8,
    parameter int N    = 8,
    parameter int SELW = 3
);
    logic [N*W-1:0]  inp_bus;
    logic [SELW-1:0] sel;
    logic            mode;
    logic            hold;
    logic [W-1:0]    w_out;
    logic [SELW-1:0] ch_out;
    logic            out_valid;

    modport master (
        output inp_bus, sel, mode, hold,
        input  w_out, ch_out, out_valid
    );

    modport slave (
        input  inp_bus, sel, mode, hold,
        output w_out, ch_out, out_valid
    );
endinterface

// File: rtl/mux_scan_reg.sv
// Registered N-channel W-bit multiplexer with manual select and an auto-scan
// mode that dwells DWELL clocks on each channel.
module mux_scan_reg #(
    parameter int W     = 8,
    parameter int N     = 8,
    parameter int SELW  = 3,
    parameter int DWELL = 4
) (
    input logic          clk,
    input logic          rst,
    mux_scan_reg_if.slave bus
);
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int CH  = 1 << SELW;
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);
    localparam logic [DCW-1:0]  LAST_DC = DCW'(DWELL - 1);
    localparam logic [SELW:0]   N_LIM   = (SELW + 1)'(N);

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_t;

    state_t          state, state_n;
    logic [SELW-1:0] cur, cur_n;
    logic [DCW-1:0]  dc, dc_n;
    logic [W-1:0]    w_q, w_n;
    logic [SELW-1:0] ch_q, ch_n;
    logic            v_q, v_n;

    // Padded to a full 2^SELW entries so every select value indexes in range.
    logic [W-1:0] chan [CH];

    for (genvar i = 0; i < CH; i++) begin : g_chan
        if (i < N) begin : g_live
            assign chan[i] = bus.inp_bus[i*W +: W];
        end else begin : g_pad
            assign chan[i] = '0;
        end
    end

    logic            sel_ok;
    logic [W-1:0]    man_w;
    logic [SELW-1:0] man_ch;

    assign sel_ok = ({1'b0, bus.sel} < N_LIM);
    assign man_w  = sel_ok ? chan[bus.sel] : w_q;
    assign man_ch = sel_ok ? bus.sel : ch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cur   <= '0;
            dc    <= '0;
            w_q   <= '0;
            ch_q  <= '0;
            v_q   <= 1'b0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            dc    <= dc_n;
            w_q   <= w_n;
            ch_q  <= ch_n;
            v_q   <= v_n;
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        dc_n    = dc;
        w_n     = w_q;
        ch_n    = ch_q;
        v_n     = v_q;
        case (state)
            IDLE: begin
                state_n = bus.mode ? SCAN : MANUAL;
                v_n     = 1'b0;
            end
            MANUAL: begin
                w_n  = man_w;
                ch_n = man_ch;
                v_n  = sel_ok;
                if (bus.mode) begin
                    state_n = SCAN;
                    cur_n   = '0;
                    dc_n    = '0;
                end
            end
            SCAN: begin
                if (!bus.mode) begin
                    // Leaving scan: this edge already shows the manual selection.
                    w_n     = man_w;
                    ch_n    = man_ch;
                    v_n     = sel_ok;
                    state_n = MANUAL;
                    cur_n   = '0;
                    dc_n    = '0;
                end else begin
                    w_n  = chan[cur];
                    ch_n = cur;
                    v_n  = 1'b1;
                    if (!bus.hold) begin
                        if (dc == LAST_DC) begin
                            dc_n  = '0;
                            cur_n = (cur == LAST_CH) ? '0 : cur + 1'b1;
                        end else begin
                            dc_n = dc + 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.w_out     = w_q;
    assign bus.ch_out    = ch_q;
    assign bus.out_valid = v_q;
endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: an 8-channel DWELL=4 instance and a 6-channel
// DWELL=1 instance share stimulus and are checked against a position model.
module tb_mux_scan_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] data8;
    logic [2:0]  sel = '0;
    logic        mode = 1'b0;
    logic        hold = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] tab [8] = '{8'hAA, 8'hBA, 8'hBB, 8'hCB, 8'hCC, 8'hDC, 8'hDD, 8'hFF};

    mux_scan_reg_if #(.W(8), .N(8), .SELW(3)) if8 ();
    mux_scan_reg_if #(.W(8), .N(6), .SELW(3)) if6 ();

    assign if8.inp_bus = data8;
    assign if6.inp_bus = data8[47:0];
    assign if8.sel  = sel;
    assign if6.sel  = sel;
    assign if8.mode = mode;
    assign if6.mode = mode;
    assign if8.hold = hold;
    assign if6.hold = hold;

    mux_scan_reg #(.W(8), .N(8), .SELW(3), .DWELL(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    mux_scan_reg #(.W(8), .N(6), .SELW(3), .DWELL(1)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (if6.slave)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = waiting out the post-reset clock, 1 = manual, 2 = scan.
    // In scan, pos counts un-held scan edges; the channel is (pos/DWELL) mod N.
    int ncha [2] = '{8, 6};
    int dwl  [2] = '{4, 1};
    int m_w  [2] = '{0, 0};
    int m_ch [2] = '{0, 0};
    int m_v  [2] = '{0, 0};
    int phase[2] = '{0, 0};
    int pos  [2] = '{0, 0};

    function automatic int chan_val(int c);
        logic [63:0] t;
        t = data8;
        return int'(t[c*8 +: 8]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_w[d] = 0; m_ch[d] = 0; m_v[d] = 0; phase[d] = 0; pos[d] = 0;
            end else if (phase[d] == 0) begin
                phase[d] = mode ? 2 : 1;
            end else if (phase[d] == 1 || !mode) begin
                if (int'(sel) < ncha[d]) begin
                    m_w[d] = chan_val(int'(sel)); m_ch[d] = int'(sel); m_v[d] = 1;
                end else begin
                    m_v[d] = 0;
                end
                if (phase[d] == 2 || mode) pos[d] = 0;
                phase[d] = mode ? 2 : 1;
            end else begin
                m_ch[d] = (pos[d] / dwl[d]) % ncha[d];
                m_w[d]  = chan_val(m_ch[d]);
                m_v[d]  = 1;
                if (!hold) pos[d]++;
            end
        end
    end

    always @(negedge clk) begin
        check("w8",  int'(if8.w_out),     m_w[0]);
        check("ch8", int'(if8.ch_out),    m_ch[0]);
        check("v8",  int'(if8.out_valid), m_v[0]);
        check("w6",  int'(if6.w_out),     m_w[1]);
        check("ch6", int'(if6.ch_out),    m_ch[1]);
        check("v6",  int'(if6.out_valid), m_v[1]);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) data8[i*8 +: 8] = tab[i];
        step();
        step();
        check("rst_w",  int'(if8.w_out), 0);
        check("rst_ch", int'(if8.ch_out), 0);
        check("rst_v",  int'(if8.out_valid), 0);
        rst = 1'b0;
        step();
        check("idle_v", int'(if8.out_valid), 0);
        step();
        check("first_w", int'(if8.w_out), 'hAA);
        check("first_v", int'(if8.out_valid), 1);

        sel = 3'd2;
        step();
        check("sel2_w",  int'(if8.w_out), 'hBB);
        check("sel2_ch", int'(if8.ch_out), 2);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            check("sweep_w",  int'(if8.w_out), int'(tab[s]));
            check("sweep_ch", int'(if8.ch_out), s);
        end

        mode = 1'b1;
        step();
        for (int k = 0; k < 33; k++) begin
            step();
            check("scan_w",  int'(if8.w_out), int'(tab[(k / 4) % 8]));
            check("scan_ch", int'(if8.ch_out), (k / 4) % 8);
            check("scan_v",  int'(if8.out_valid), 1);
        end

        mode = 1'b0;
        step();
        mode = 1'b1;
        step();
        repeat (22) step();
        check("pre_hold_w", int'(if8.w_out), 'hDC);
        hold = 1'b1;
        repeat (3) begin
            step();
            check("hold_w",  int'(if8.w_out), 'hDC);
            check("hold_ch", int'(if8.ch_out), 5);
        end
        data8[47:40] = 8'h5A;
        step();
        check("hold_live_w", int'(if8.w_out), 'h5A);
        hold = 1'b0;
        step();
        check("rel1_w", int'(if8.w_out), 'h5A);
        step();
        check("rel2_w", int'(if8.w_out), 'h5A);
        step();
        check("ch6_w",  int'(if8.w_out), 'hDD);
        check("ch6_ch", int'(if8.ch_out), 6);

        mode = 1'b0;
        sel  = 3'd3;
        step();
        check("leave_w",  int'(if8.w_out), 'hCB);
        check("leave_ch", int'(if8.ch_out), 3);
        mode = 1'b1;
        step();
        repeat (4) begin
            step();
            check("restart_w", int'(if8.w_out), 'hAA);
        end
        step();
        check("restart_next_w", int'(if8.w_out), 'hBA);

        mode = 1'b0;
        sel  = 3'd1;
        step();
        check("n6_sel1_w", int'(if6.w_out), 'hBA);
        sel = 3'd7;
        step();
        check("n6_ill_v",  int'(if6.out_valid), 0);
        check("n6_ill_w",  int'(if6.w_out), 'hBA);
        check("n6_ill_ch", int'(if6.ch_out), 1);
        check("n8_sel7_w", int'(if8.w_out), 'hFF);
        sel = 3'd1;
        step();
        check("n6_back_w", int'(if6.w_out), 'hBA);
        check("n6_back_v", int'(if6.out_valid), 1);

        mode = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("arst_w8", int'(if8.w_out), 0);
        check("arst_ch", int'(if8.ch_out), 0);
        check("arst_v8", int'(if8.out_valid), 0);
        check("arst_v6", int'(if6.out_valid), 0);
        step();
        step();
        rst = 1'b0;
        step();
        check("rel_idle_v", int'(if8.out_valid), 0);
        step();
        check("rel_w8",  int'(if8.w_out), 'hAA);
        check("rel_v8",  int'(if8.out_valid), 1);
        check("rel_w6",  int'(if6.w_out), 'hAA);
        step();
        check("dw1_w6",  int'(if6.w_out), 'hBA);
        check("dw4_w8",  int'(if8.w_out), 'hAA);
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
